// File: rtl/avalon_mem_arbiter_if.sv
// Bus bundle between the CPU fetch/data units, the arbiter and the Avalon slave.
// Handshake: a requester holds its read/write high until it samples its waitrequest low at a rising edge.
interface avalon_mem_arbiter_if;
    logic [31:0] i_address;
    logic        i_read;
    logic        i_waitrequest;
    logic [31:0] i_readdata;

    logic [31:0] d_address;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_writedata;
    logic [3:0]  d_byteenable;
    logic        d_waitrequest;
    logic [31:0] d_readdata;

    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;

    // Arbiter view: serves the two CPU requesters and masters the Avalon port.
    modport master (
        input  i_address, i_read,
        output i_waitrequest, i_readdata,
        input  d_address, d_read, d_write, d_writedata, d_byteenable,
        output d_waitrequest, d_readdata,
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata
    );

    // Environment view: CPU units plus the Avalon slave.
    modport slave (
        output i_address, i_read,
        input  i_waitrequest, i_readdata,
        output d_address, d_read, d_write, d_writedata, d_byteenable,
        input  d_waitrequest, d_readdata,
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata
    );
endinterface

// File: rtl/avalon_mem_arbiter.sv
// Round-robin arbiter sharing one Avalon port between instruction fetch and load/store,
// holding the grant until the access completes, with a waitrequest watchdog.
module avalon_mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] TIMEOUT_RDATA  = 32'hFFFFFFFF
) (
    input  logic                  clk,
    input  logic                  reset,
    avalon_mem_arbiter_if.master  bus,
    output logic [1:0]            grant,
    output logic                  bus_error,
    output logic [1:0]            dbg_state_o
);

    localparam int unsigned CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam bit WD_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        ERR   = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic          last_d_q, last_d_d;   // 1: data was served last
    logic [CW-1:0] cnt_q, cnt_d;
    logic          berr_q, berr_d;

    logic i_req, d_req, own_req;

    assign i_req   = bus.i_read;
    assign d_req   = bus.d_read | bus.d_write;
    assign own_req = (state_q == GNT_I) ? i_req : d_req;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d_d = last_d_q;
        cnt_d    = cnt_q;
        berr_d   = berr_q;
        case (state_q)
            IDLE: begin
                if (i_req && (!d_req || last_d_q)) begin
                    state_d  = GNT_I;
                    grant_d  = 2'b01;
                    last_d_d = 1'b0;
                end else if (d_req) begin
                    state_d  = GNT_D;
                    grant_d  = 2'b10;
                    last_d_d = 1'b1;
                end
            end
            GNT_I, GNT_D: begin
                // A dropped request is an abort, not an error.
                if (!own_req || !bus.waitrequest) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                    cnt_d   = '0;
                end else if (WD_EN && (cnt_q == CNT_LAST)) begin
                    state_d = ERR;
                    berr_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ERR: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    always_comb begin
        bus.address       = 32'h0;
        bus.read          = 1'b0;
        bus.write         = 1'b0;
        bus.writedata     = 32'h0;
        bus.byteenable    = 4'h0;
        bus.i_waitrequest = 1'b1;
        bus.i_readdata    = 32'h0;
        bus.d_waitrequest = 1'b1;
        bus.d_readdata    = 32'h0;
        case (state_q)
            GNT_I: begin
                bus.address       = bus.i_address;
                bus.read          = bus.i_read;
                bus.byteenable    = 4'hF;
                bus.i_waitrequest = bus.waitrequest;
                bus.i_readdata    = bus.readdata;
            end
            GNT_D: begin
                bus.address       = bus.d_address;
                bus.write         = bus.d_write;
                bus.read          = bus.d_read & ~bus.d_write;
                bus.writedata     = bus.d_writedata;
                bus.byteenable    = bus.d_byteenable;
                bus.d_waitrequest = bus.waitrequest;
                bus.d_readdata    = bus.readdata;
            end
            ERR: begin
                // Release the stalled owner with a poison value.
                if (grant_q == 2'b01) begin
                    bus.i_waitrequest = 1'b0;
                    bus.i_readdata    = TIMEOUT_RDATA;
                end else begin
                    bus.d_waitrequest = 1'b0;
                    bus.d_readdata    = TIMEOUT_RDATA;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= 2'b00;
            last_d_q <= 1'b0;
            cnt_q    <= '0;
            berr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_d_q <= last_d_d;
            cnt_q    <= cnt_d;
            berr_q   <= berr_d;
        end
    end

    assign grant       = grant_q;
    assign bus_error   = berr_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/avalon_mem_arbiter.md
Name: avalon_mem_arbiter

Overview:
Two-master to one-slave arbiter that shares the CPU's single Avalon memory-mapped port between the instruction-fetch path and the load/store data path. Sits between the CPU's internal fetch/data units and the external RAM/Avalon bus. Round-robin arbitration holds the grant until the Avalon transaction completes. A wait watchdog flags a hung slave.

Parameters:
TIMEOUT_CYCLES, 255, max consecutive waitrequest-high cycles tolerated in a grant; 0 disables the watchdog.
TIMEOUT_RDATA, 32'hFFFFFFFF, readdata returned to the requester on a timed-out access.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous active-high reset
i_address  input  32  fetch address
i_read  input  1  fetch read request
i_waitrequest  output  1  fetch stall
i_readdata  output  32  fetch read data
d_address  input  32  data address
d_read  input  1  data read request
d_write  input  1  data write request
d_writedata  input  32  data write data
d_byteenable  input  4  data byte lanes
d_waitrequest  output  1  data stall
d_readdata  output  32  data read data
address  output  32  Avalon master address
read  output  1  Avalon read
write  output  1  Avalon write
writedata  output  32  Avalon write data
byteenable  output  4  Avalon byte lanes
waitrequest  input  1  Avalon slave stall
readdata  input  32  Avalon read data
grant  output  2  current owner: 00 none, 01 fetch, 10 data
bus_error  output  1  sticky watchdog flag

Behaviour:
- Reset (async, active-high): state IDLE; grant=00; read=write=0; address/writedata=0; byteenable=0; bus_error=0; wait counter=0; last-served pointer=fetch, so data wins the first tie. Reset mid-transaction drops read/write immediately.
- Request definitions: fetch req = i_read. Data req = d_read|d_write. If d_read and d_write are both high, treat it as a write.
- States: IDLE, GNT_I, GNT_D, ERR.
- IDLE:
  - Master read/write=0. Any active requester sees waitrequest=1.
  - At the clock edge: if only one requester is pending, go to its GNT state.
  - If both are pending, grant the one not last served, then update the pointer.
  - If none is pending, stay in IDLE.
  - Arbitration costs one cycle.
- GNT_x, combinational:
  - address/read/write/writedata/byteenable follow the owner. For fetch: write=0, writedata=0, byteenable=4'hF.
  - x_waitrequest = waitrequest; x_readdata = readdata.
  - Non-owner waitrequest=1; non-owner readdata=0.
- GNT_x, completion: owner request high and waitrequest low at the edge -> transaction done, go to IDLE. Minimum 2 cycles per access for a zero-wait slave. There is no back-to-back bypass.
- GNT_x, abort: owner request low at the edge (protocol violation) -> IDLE with no error.
- Watchdog:
  - Counter increments each GNT cycle with waitrequest high; cleared on leaving GNT.
  - If TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES-1 with waitrequest still high at the edge, go to ERR.
- ERR (1 cycle):
  - read=write=0.
  - Owner waitrequest=0 and owner readdata=TIMEOUT_RDATA.
  - bus_error set; it stays set until reset.
  - Next state IDLE. grant keeps its owner value during ERR.
- grant is registered and equals 00 in IDLE.
- Simultaneous new request and completion: the new request is evaluated in the following IDLE cycle.

Test Plan:
- Zero-wait fetch only: i_read=1, i_address=0x04, slave returns 0x24020010 with waitrequest=0 -> grant 01 on cycle 2, i_readdata=0x24020010 with i_waitrequest=0 in that cycle, then IDLE; repeated fetches complete every 2 cycles.
- Fetch and data requests held continuously from reset -> grants alternate 10,01,10,01; neither requester is starved.
- Data write 0xDEADBEEF, byteenable 4'b0011, slave waitrequest high 3 cycles -> write/address/byteenable stable for 4 cycles; d_waitrequest mirrors the slave; i_waitrequest=1 throughout.
- TIMEOUT_CYCLES=4, slave holds waitrequest high forever on a data read -> after 4 GNT cycles an ERR cycle occurs with d_waitrequest=0 and d_readdata=0xFFFFFFFF; bus_error=1 persists; the next fetch still completes.
- Reset asserted mid-GNT_D with waitrequest high -> read/write/grant go to 0 immediately, asynchronously; after reset release with both requesting, data is granted first.
- Owner drops d_read while stalled -> return to IDLE next cycle; bus_error stays 0; a pending fetch is granted next.
